fwd_ctrl: RTL and testbench
===========================

Name: fwd_ctrl

Overview:
- Control-side counterpart of the EX-stage forwarding muxes. It produces the FWA/FWB/FWhi/FWlo selects that EX consumes, and the load-use stall request.
- Keeps its own shadow pipeline of destination/write-enable information for the MEM and WB stages.
- Evaluates the instruction leaving ID against older in-flight writers, and registers the selects so they are valid during that instruction's EX cycle.
- Sits beside the ID/EX pipeline register; its outputs feed the EX stage directly.

Parameters:
ADDR_W, 5, register address width (RegAddrWidth)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
rs_ID  in  ADDR_W  rs of instruction in ID (enters EX next edge)
rt_ID  in  ADDR_W  rt of instruction in ID
target_EX  in  ADDR_W  destination of instruction currently in EX (post RegDes mux)
we_EX  in  1  instruction in EX writes GPR
mem_read_EX  in  1  instruction in EX is a load
we_hi_EX  in  1  instruction in EX writes HI
we_lo_EX  in  1  instruction in EX writes LO
hold  in  1  global pipeline freeze (e.g. memory wait)
flush  in  1  ID->EX transfer is squashed (bubble into EX)
FWA  out  2  srcA select: 00 regfile, 01 data_out_MEM, 10 data_out_WB
FWB  out  2  srcB select, same encoding
FWhi  out  2  HI select: 00 hi, 01 hi_MEM, 10 hi_WB
FWlo  out  2  LO select, same encoding
stall_ID  out  1  load-use stall request, combinational

Behaviour:
- State: MEM shadow {tgt_M, we_M, we_hi_M, we_lo_M} and registered FWA/FWB/FWhi/FWlo.
- Reset: all state 0. All FW outputs 00. stall_ID is 0 while rst is asserted.
- stall_ID = mem_read_EX & we_EX & (target_EX != 0) & (target_EX == rs_ID | target_EX == rt_ID). Forced 0 during rst.
- Edge update priority: rst > hold > flush > stall_ID > normal.
- hold=1: all state frozen, including FW outputs. stall_ID still evaluated.
- Shadow advance (every non-hold edge, including flush and stall): tgt_M<=target_EX, we_M<=we_EX, we_hi_M<=we_hi_EX, we_lo_M<=we_lo_EX.
- flush=1 or stall_ID=1 (no hold): FW outputs <= 00, because EX receives a bubble.
- Normal edge, per source s in {rs_ID→FWA, rt_ID→FWB}:
  - 01 if we_EX & target_EX==s & s!=0. The producer will be in MEM during the consumer's EX.
  - else 10 if we_M & tgt_M==s & s!=0.
  - else 00.
  - The EX match wins over the MEM-shadow match (youngest producer).
- FWhi: 01 if we_hi_EX; else 10 if we_hi_M; else 00. FWlo uses the same rule with the lo enables.
- Register 0 is never forwarded.
- Producers three or more instructions older are served by the regfile (write-first in WB half-cycle). They are not this block's concern.
- Load-use:
  - A one-cycle stall, then the consumer re-evaluates.
  - The load is now in the MEM shadow, so the result is select 10 (data_out_WB).
  - The bubble occupies the EX-side stage.
- Latency: selects are valid the cycle after the ID-side inputs are sampled, i.e. throughout the consumer's EX cycle.

Decomposition:
- Shared defines (existing global defines header): RegAddrWidth, and FW encodings FW_RF=2'b00, FW_MEM=2'b01, FW_WB=2'b10.
- One sub-module is natural: fwd_sel. It is combinational and takes one source address plus the EX/MEM-shadow tags, returning the 2-bit select. It is instantiated twice (rs, rt).
- HI/LO logic is inline.

Test Plan:
- Back-to-back dependency: target_EX=8, we_EX=1, rs_ID=8, rt_ID=9 → next cycle FWA=01, FWB=00.
- Distance two: producer with target 8 moves to the MEM shadow; new EX has we_EX=0; rt_ID=8 → FWB=10.
- Both stages write $8 (EX and MEM shadow), rs_ID=8 → FWA=01 (youngest wins). Source $0 with target_EX=0, we_EX=1 → FWA=00.
- Load-use: mem_read_EX=1, we_EX=1, target_EX=5, rs_ID=5 → stall_ID=1 in the same cycle. Next cycle FWA=00 (bubble). Following cycle, with rs_ID=5 held, FWA=10.
- HI/LO: we_hi_EX=1 → FWhi=01, FWlo=00. Next cycle, with we_hi_EX=0 → FWhi=10. hold=1 across one edge → outputs unchanged.
- Flush/reset: flush=1 with a matching dependency → FW outputs 00, shadow still advances. Assert rst mid-stream → all outputs 00 immediately, asynchronously.

Source files
------------

// File: rtl/fwd_ctrl_pkg.sv
// fwd_ctrl_pkg: register address width and the EX forwarding select encodings
package fwd_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [1:0] FW_RF  = 2'b00;
  localparam logic [1:0] FW_MEM = 2'b01;
  localparam logic [1:0] FW_WB  = 2'b10;
endpackage

// File: rtl/fwd_ctrl_sel.sv
// fwd_ctrl_sel: one source's forwarding select (src, EX tag/we, MEM-shadow tag/we -> sel); EX match wins, $0 never forwarded
module fwd_ctrl_sel
  import fwd_ctrl_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] tgt_ex,
  input  logic              we_ex,
  input  logic [ADDR_W-1:0] tgt_m,
  input  logic              we_m,
  output logic [1:0]        sel
);
  always_comb begin
    sel = (src == '0) ? FW_RF :
          (we_ex && tgt_ex == src) ? FW_MEM :
          (we_m && tgt_m == src) ? FW_WB : FW_RF;
  end
endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: registered EX forwarding selects (FWA/FWB/FWhi/FWlo) from ID sources vs EX/MEM-shadow writers, plus combinational load-use stall_ID
module fwd_ctrl
  import fwd_ctrl_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_ID,
  input  logic [ADDR_W-1:0] rt_ID,
  input  logic [ADDR_W-1:0] target_EX,
  input  logic              we_EX,
  input  logic              mem_read_EX,
  input  logic              we_hi_EX,
  input  logic              we_lo_EX,
  input  logic              hold,
  input  logic              flush,
  output logic [1:0]        FWA,
  output logic [1:0]        FWB,
  output logic [1:0]        FWhi,
  output logic [1:0]        FWlo,
  output logic              stall_ID
);
  logic [ADDR_W-1:0] tgt_m_q, tgt_m_d;
  logic we_m_q, we_m_d, we_hi_m_q, we_hi_m_d, we_lo_m_q, we_lo_m_d;
  logic [1:0] fwa_q, fwa_d, fwb_q, fwb_d, fwhi_q, fwhi_d, fwlo_q, fwlo_d;
  logic [1:0] sel_a, sel_b;
  logic bubble;
  fwd_ctrl_sel #(.ADDR_W(ADDR_W)) u_sel_a (
    .src(rs_ID), .tgt_ex(target_EX), .we_ex(we_EX), .tgt_m(tgt_m_q), .we_m(we_m_q), .sel(sel_a)
  );
  fwd_ctrl_sel #(.ADDR_W(ADDR_W)) u_sel_b (
    .src(rt_ID), .tgt_ex(target_EX), .we_ex(we_EX), .tgt_m(tgt_m_q), .we_m(we_m_q), .sel(sel_b)
  );
  always_comb begin
    stall_ID  = !rst && mem_read_EX && we_EX && target_EX != '0 &&
                (target_EX == rs_ID || target_EX == rt_ID);
    bubble    = flush || stall_ID;
    tgt_m_d   = hold ? tgt_m_q : target_EX;
    we_m_d    = hold ? we_m_q : we_EX;
    we_hi_m_d = hold ? we_hi_m_q : we_hi_EX;
    we_lo_m_d = hold ? we_lo_m_q : we_lo_EX;
    fwa_d     = hold ? fwa_q : bubble ? FW_RF : sel_a;
    fwb_d     = hold ? fwb_q : bubble ? FW_RF : sel_b;
    fwhi_d    = hold ? fwhi_q : bubble ? FW_RF :
                we_hi_EX ? FW_MEM : we_hi_m_q ? FW_WB : FW_RF;
    fwlo_d    = hold ? fwlo_q : bubble ? FW_RF :
                we_lo_EX ? FW_MEM : we_lo_m_q ? FW_WB : FW_RF;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_m_q   <= '0;
      we_m_q    <= 1'b0;
      we_hi_m_q <= 1'b0;
      we_lo_m_q <= 1'b0;
      fwa_q     <= FW_RF;
      fwb_q     <= FW_RF;
      fwhi_q    <= FW_RF;
      fwlo_q    <= FW_RF;
    end else begin
      tgt_m_q   <= tgt_m_d;
      we_m_q    <= we_m_d;
      we_hi_m_q <= we_hi_m_d;
      we_lo_m_q <= we_lo_m_d;
      fwa_q     <= fwa_d;
      fwb_q     <= fwb_d;
      fwhi_q    <= fwhi_d;
      fwlo_q    <= fwlo_d;
    end
  end
  assign FWA  = fwa_q;
  assign FWB  = fwb_q;
  assign FWhi = fwhi_q;
  assign FWlo = fwlo_q;
endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed scenario tasks with hand-computed forwarding selects and stall
module tb_fwd_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs_ID, rt_ID, target_EX;
  logic we_EX, mem_read_EX, we_hi_EX, we_lo_EX, hold, flush;
  logic [1:0] FWA, FWB, FWhi, FWlo;
  logic stall_ID;
  int pass_cnt = 0;
  int total_cnt = 0;
  fwd_ctrl dut (
    .clk(clk), .rst(rst), .rs_ID(rs_ID), .rt_ID(rt_ID), .target_EX(target_EX),
    .we_EX(we_EX), .mem_read_EX(mem_read_EX), .we_hi_EX(we_hi_EX), .we_lo_EX(we_lo_EX),
    .hold(hold), .flush(flush), .FWA(FWA), .FWB(FWB), .FWhi(FWhi), .FWlo(FWlo),
    .stall_ID(stall_ID)
  );
  always #5 clk = ~clk;
  task automatic idle();
    rs_ID = 0; rt_ID = 0; target_EX = 0;
    we_EX = 0; mem_read_EX = 0; we_hi_EX = 0; we_lo_EX = 0; hold = 0; flush = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    idle();
    rst = 1;
    mem_read_EX = 1; we_EX = 1; target_EX = 5; rs_ID = 5;
    #2;
    total_cnt++;
    if ({FWA, FWB, FWhi, FWlo} !== 8'h00) $display("FAIL reset_outputs got=%h exp=00", {FWA, FWB, FWhi, FWlo});
    else pass_cnt++;
    total_cnt++;
    if (stall_ID !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall_ID);
    else pass_cnt++;
    step();
    idle();
    rst = 0;
    step();
  endtask
  task automatic test_back_to_back();
    idle();
    target_EX = 8; we_EX = 1; rs_ID = 8; rt_ID = 9;
    step();
    total_cnt++;
    if (FWA !== 2'b01) $display("FAIL b2b_fwa got=%b exp=01", FWA);
    else pass_cnt++;
    total_cnt++;
    if (FWB !== 2'b00) $display("FAIL b2b_fwb got=%b exp=00", FWB);
    else pass_cnt++;
  endtask
  task automatic test_distance_two();
    idle();
    rt_ID = 8;
    step();
    total_cnt++;
    if (FWB !== 2'b10) $display("FAIL dist2_fwb got=%b exp=10", FWB);
    else pass_cnt++;
    total_cnt++;
    if (FWA !== 2'b00) $display("FAIL dist2_fwa_r0 got=%b exp=00", FWA);
    else pass_cnt++;
  endtask
  task automatic test_youngest();
    idle();
    target_EX = 8; we_EX = 1;
    step();
    rs_ID = 8;
    step();
    total_cnt++;
    if (FWA !== 2'b01) $display("FAIL youngest_fwa got=%b exp=01", FWA);
    else pass_cnt++;
    target_EX = 0; rs_ID = 0; rt_ID = 8;
    step();
    total_cnt++;
    if (FWA !== 2'b00) $display("FAIL zero_reg_fwa got=%b exp=00", FWA);
    else pass_cnt++;
    total_cnt++;
    if (FWB !== 2'b10) $display("FAIL mem_shadow_fwb got=%b exp=10", FWB);
    else pass_cnt++;
  endtask
  task automatic test_load_use();
    idle();
    step();
    mem_read_EX = 1; we_EX = 1; target_EX = 0; rs_ID = 0;
    #1;
    total_cnt++;
    if (stall_ID !== 1'b0) $display("FAIL lu_r0_stall got=%b exp=0", stall_ID);
    else pass_cnt++;
    target_EX = 5; rs_ID = 5;
    #1;
    total_cnt++;
    if (stall_ID !== 1'b1) $display("FAIL lu_stall got=%b exp=1", stall_ID);
    else pass_cnt++;
    rs_ID = 0; rt_ID = 5;
    #1;
    total_cnt++;
    if (stall_ID !== 1'b1) $display("FAIL lu_stall_rt got=%b exp=1", stall_ID);
    else pass_cnt++;
    rs_ID = 5; rt_ID = 0;
    step();
    total_cnt++;
    if (FWA !== 2'b00) $display("FAIL lu_bubble_fwa got=%b exp=00", FWA);
    else pass_cnt++;
    mem_read_EX = 0; we_EX = 0; target_EX = 0;
    #1;
    total_cnt++;
    if (stall_ID !== 1'b0) $display("FAIL lu_release got=%b exp=0", stall_ID);
    else pass_cnt++;
    step();
    total_cnt++;
    if (FWA !== 2'b10) $display("FAIL lu_retry_fwa got=%b exp=10", FWA);
    else pass_cnt++;
  endtask
  task automatic test_hilo_hold();
    idle();
    step();
    we_hi_EX = 1;
    step();
    total_cnt++;
    if (FWhi !== 2'b01) $display("FAIL hi_ex got=%b exp=01", FWhi);
    else pass_cnt++;
    total_cnt++;
    if (FWlo !== 2'b00) $display("FAIL lo_idle got=%b exp=00", FWlo);
    else pass_cnt++;
    hold = 1; we_hi_EX = 0; we_lo_EX = 1;
    mem_read_EX = 1; we_EX = 1; target_EX = 7; rs_ID = 7;
    #1;
    total_cnt++;
    if (stall_ID !== 1'b1) $display("FAIL hold_stall got=%b exp=1", stall_ID);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({FWA, FWB, FWhi, FWlo} !== 8'b00_00_01_00) $display("FAIL hold_frozen got=%b exp=00000100", {FWA, FWB, FWhi, FWlo});
    else pass_cnt++;
    idle();
    step();
    total_cnt++;
    if (FWhi !== 2'b10) $display("FAIL hi_wb_after_hold got=%b exp=10", FWhi);
    else pass_cnt++;
    total_cnt++;
    if (FWlo !== 2'b00) $display("FAIL lo_shadow_frozen got=%b exp=00", FWlo);
    else pass_cnt++;
    we_lo_EX = 1;
    step();
    total_cnt++;
    if ({FWhi, FWlo} !== 4'b0001) $display("FAIL lo_ex got=%b exp=0001", {FWhi, FWlo});
    else pass_cnt++;
  endtask
  task automatic test_flush();
    idle();
    step();
    target_EX = 8; we_EX = 1; rs_ID = 8; we_hi_EX = 1; flush = 1;
    step();
    total_cnt++;
    if ({FWA, FWhi} !== 4'b0000) $display("FAIL flush_out got=%b exp=0000", {FWA, FWhi});
    else pass_cnt++;
    idle();
    rs_ID = 8;
    step();
    total_cnt++;
    if ({FWA, FWhi} !== 4'b1010) $display("FAIL flush_shadow got=%b exp=1010", {FWA, FWhi});
    else pass_cnt++;
  endtask
  task automatic test_async_reset();
    idle();
    target_EX = 8; we_EX = 1; rs_ID = 8; we_hi_EX = 1;
    step();
    total_cnt++;
    if ({FWA, FWhi} !== 4'b0101) $display("FAIL pre_reset got=%b exp=0101", {FWA, FWhi});
    else pass_cnt++;
    #3;
    rst = 1;
    #1;
    total_cnt++;
    if ({FWA, FWB, FWhi, FWlo} !== 8'h00) $display("FAIL async_reset got=%h exp=00", {FWA, FWB, FWhi, FWlo});
    else pass_cnt++;
    idle();
    step();
    rst = 0;
    rs_ID = 8;
    step();
    total_cnt++;
    if ({FWA, FWhi} !== 4'b0000) $display("FAIL post_reset_shadow got=%b exp=0000", {FWA, FWhi});
    else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_distance_two();
    test_youngest();
    test_load_use();
    test_hilo_hold();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
